// File: rtl/result_stack.sv
// LIFO stack that captures results from an upstream add/sub stage on each
// rising edge of its completion flag and returns them to a consumer on pop.
module result_stack #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_ready,
    input  logic                       pop,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             rdy_d_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;
    logic             overflow_r;
    logic             underflow_r;

    logic             push_s;
    logic             is_full_s;
    logic             is_empty_s;
    logic [CW-1:0]    top_s;
    logic [CW-1:0]    count_nxt_s;
    logic [WIDTH-1:0] out_data_nxt_s;
    logic             out_valid_nxt_s;
    logic             overflow_nxt_s;
    logic             underflow_nxt_s;
    logic             mem_we_s;
    logic [AW-1:0]    mem_addr_s;

    // Next-state decode for the stack pointer, output word and sticky flags.
    always_comb begin
        push_s          = in_ready & ~rdy_d_r;
        is_full_s       = (count_r == DEPTH_C);
        is_empty_s      = (count_r == ZERO_C);
        top_s           = count_r - ONE_C;
        count_nxt_s     = count_r;
        out_data_nxt_s  = out_data_r;
        out_valid_nxt_s = 1'b0;
        overflow_nxt_s  = overflow_r;
        underflow_nxt_s = underflow_r;
        mem_we_s        = 1'b0;
        mem_addr_s      = count_r[AW-1:0];
        case ({push_s, pop})
            2'b11: begin
                // Combined push/pop swaps the top in place, so a full stack never overflows here.
                if (!is_empty_s) begin
                    out_data_nxt_s  = mem_r[top_s[AW-1:0]];
                    out_valid_nxt_s = 1'b1;
                    mem_we_s        = 1'b1;
                    mem_addr_s      = top_s[AW-1:0];
                end else begin
                    mem_we_s        = 1'b1;
                    mem_addr_s      = {AW{1'b0}};
                    count_nxt_s     = ONE_C;
                    underflow_nxt_s = 1'b1;
                end
            end
            2'b10: begin
                if (!is_full_s) begin
                    mem_we_s    = 1'b1;
                    count_nxt_s = count_r + ONE_C;
                end else begin
                    overflow_nxt_s = 1'b1;
                end
            end
            2'b01: begin
                if (!is_empty_s) begin
                    out_data_nxt_s  = mem_r[top_s[AW-1:0]];
                    out_valid_nxt_s = 1'b1;
                    count_nxt_s     = top_s;
                end else begin
                    underflow_nxt_s = 1'b1;
                end
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // Control and output registers; rdy_d resets high so a level already up at release is not a push.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_d_r     <= 1'b1;
            count_r     <= ZERO_C;
            out_data_r  <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            rdy_d_r     <= in_ready;
            count_r     <= count_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
        end
    end

    // Storage array; contents are left as-is on reset because count alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_s) begin
            mem_r[mem_addr_s] <= in_data;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign count     = count_r;
    assign full      = is_full_s;
    assign empty     = is_empty_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_result_stack.sv
// Self-checking bench for result_stack: directed scenarios against fixed
// expected values, then randomized traffic against a queue-based stack model.
module tb_result_stack;

    localparam int WIDTH = 3;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             pop;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    int errors = 0;
    int checks = 0;

    // Reference model: a plain LIFO queue plus flags derived from the rules.
    int stk[$];
    bit m_rdy_d;
    bit m_ov;
    bit m_ovf;
    bit m_udf;
    int m_od;

    result_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .pop       (pop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic rdy, input logic [WIDTH-1:0] d, input logic p);
        bit push;
        rst      = r;
        in_ready = rdy;
        in_data  = d;
        pop      = p;
        @(posedge clk);
        if (r) begin
            stk.delete();
            m_rdy_d = 1'b1;
            m_ov    = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_od    = 0;
        end else begin
            push    = rdy && !m_rdy_d;
            m_rdy_d = rdy;
            m_ov    = 1'b0;
            if (push && p) begin
                if (stk.size() > 0) begin
                    m_od = stk[stk.size()-1];
                    stk[stk.size()-1] = int'(d);
                    m_ov = 1'b1;
                end else begin
                    stk.push_back(int'(d));
                    m_udf = 1'b1;
                end
            end else if (push) begin
                if (stk.size() < DEPTH) stk.push_back(int'(d));
                else m_ovf = 1'b1;
            end else if (p) begin
                if (stk.size() > 0) begin
                    m_od = stk.pop_back();
                    m_ov = 1'b1;
                end else begin
                    m_udf = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic push_pulse(input logic [WIDTH-1:0] d);
        step(1'b0, 1'b1, d, 1'b0);
        step(1'b0, 1'b0, d, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 3'd5, 1'b1);
        step(1'b1, 1'b1, 3'd5, 1'b1);
        step(1'b1, 1'b1, 3'd5, 1'b1);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 3'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {overflow, underflow}); end
        checks++; if ({full, empty} !== 2'b01) begin errors++; $display("FAIL reset_full_empty: got %b expected 01", {full, empty}); end
        // Released with in_ready still high: no push until a fresh edge.
        step(1'b0, 1'b1, 3'd5, 1'b0);
        step(1'b0, 1'b1, 3'd5, 1'b0);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_release_nopush: got %0d expected 0", count); end
        step(1'b0, 1'b0, 3'd2, 1'b0);
        step(1'b0, 1'b1, 3'd2, 1'b0);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL reset_fresh_edge: got %0d expected 1", count); end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] exp [3];
        exp[0] = 3'd1; exp[1] = 3'd5; exp[2] = 3'd3;
        do_reset();
        push_pulse(3'd3);
        push_pulse(3'd5);
        push_pulse(3'd1);
        checks++; if ({count, empty} !== {4'd3, 1'b0}) begin errors++; $display("FAIL basic_fill: got count=%0d empty=%b expected 3 0", count, empty); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'd0, 1'b1);
            checks++;
            if ({out_valid, out_data} !== {1'b1, exp[i]}) begin
                errors++; $display("FAIL basic_pop%0d: got valid=%b data=%0d expected 1 %0d", i, out_valid, out_data, exp[i]);
            end
        end
        step(1'b0, 1'b0, 3'd0, 1'b0);
        checks++; if ({out_valid, empty, count} !== {1'b0, 1'b1, 4'd0}) begin errors++; $display("FAIL basic_drained: got valid=%b empty=%b count=%0d expected 0 1 0", out_valid, empty, count); end
    endtask

    task automatic test_level_hold();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd6, 1'b0);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL level_hold_count: got %0d expected 1", count); end
        step(1'b0, 1'b0, 3'd0, 1'b1);
        checks++; if ({out_valid, out_data} !== {1'b1, 3'd6}) begin errors++; $display("FAIL level_hold_pop: got valid=%b data=%0d expected 1 6", out_valid, out_data); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) push_pulse(3'(i));
        checks++; if ({full, count, overflow} !== {1'b1, 4'd8, 1'b0}) begin errors++; $display("FAIL ovf_full: got full=%b count=%0d ovf=%b expected 1 8 0", full, count, overflow); end
        push_pulse(3'd2);
        checks++; if ({full, count, overflow} !== {1'b1, 4'd8, 1'b1}) begin errors++; $display("FAIL ovf_drop: got full=%b count=%0d ovf=%b expected 1 8 1", full, count, overflow); end
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b0, 3'd0, 1'b1);
            checks++;
            if ({out_valid, out_data} !== {1'b1, 3'(i)}) begin
                errors++; $display("FAIL ovf_pop%0d: got valid=%b data=%0d expected 1 %0d", i, out_valid, out_data, i);
            end
        end
        checks++; if ({empty, overflow} !== 2'b11) begin errors++; $display("FAIL ovf_sticky: got empty=%b ovf=%b expected 1 1", empty, overflow); end
    endtask

    task automatic test_underflow();
        do_reset();
        step(1'b0, 1'b0, 3'd0, 1'b1);
        checks++; if ({underflow, out_valid, count, out_data} !== {1'b1, 1'b0, 4'd0, 3'd0}) begin
            errors++; $display("FAIL udf_empty_pop: got udf=%b valid=%b count=%0d data=%0d expected 1 0 0 0", underflow, out_valid, count, out_data);
        end
        step(1'b0, 1'b1, 3'd4, 1'b1);
        checks++; if ({underflow, out_valid, count} !== {1'b1, 1'b0, 4'd1}) begin
            errors++; $display("FAIL udf_pushpop_empty: got udf=%b valid=%b count=%0d expected 1 0 1", underflow, out_valid, count);
        end
        step(1'b0, 1'b0, 3'd0, 1'b1);
        checks++; if ({out_valid, out_data} !== {1'b1, 3'd4}) begin errors++; $display("FAIL udf_after_pop: got valid=%b data=%0d expected 1 4", out_valid, out_data); end
    endtask

    task automatic test_push_pop();
        do_reset();
        push_pulse(3'd2);
        push_pulse(3'd4);
        step(1'b0, 1'b1, 3'd7, 1'b1);
        checks++; if ({out_valid, out_data, count, overflow} !== {1'b1, 3'd4, 4'd2, 1'b0}) begin
            errors++; $display("FAIL pushpop_swap: got valid=%b data=%0d count=%0d ovf=%b expected 1 4 2 0", out_valid, out_data, count, overflow);
        end
        step(1'b0, 1'b0, 3'd0, 1'b1);
        checks++; if (out_data !== 3'd7) begin errors++; $display("FAIL pushpop_newtop: got %0d expected 7", out_data); end
        step(1'b0, 1'b0, 3'd0, 1'b1);
        checks++; if (out_data !== 3'd2) begin errors++; $display("FAIL pushpop_bottom: got %0d expected 2", out_data); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_pulse(3'd1);
        push_pulse(3'd2);
        step(1'b0, 1'b0, 3'd0, 1'b1);
        step(1'b1, 1'b0, 3'd0, 1'b1);
        checks++; if ({count, out_valid, out_data} !== {4'd0, 1'b0, 3'd0}) begin
            errors++; $display("FAIL mid_reset: got count=%0d valid=%b data=%0d expected 0 0 0", count, out_valid, out_data);
        end
    endtask

    task automatic test_random();
        logic r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 59) == 0);
            step(r, 1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom_range(0, 2) == 0));
            checks++; if (count !== CW'(stk.size())) begin errors++; $display("FAIL rand_count@%0d: got %0d expected %0d", n, count, stk.size()); end
            checks++; if ({full, empty} !== {stk.size() == DEPTH, stk.size() == 0}) begin errors++; $display("FAIL rand_full_empty@%0d: got %b%b", n, full, empty); end
            checks++; if ({overflow, underflow} !== {m_ovf, m_udf}) begin errors++; $display("FAIL rand_flags@%0d: got %b%b expected %b%b", n, overflow, underflow, m_ovf, m_udf); end
            checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rand_valid@%0d: got %b expected %b", n, out_valid, m_ov); end
            if (m_ov) begin
                checks++; if (out_data !== 3'(m_od)) begin errors++; $display("FAIL rand_data@%0d: got %0d expected %0d", n, out_data, m_od); end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_ready = 1'b0;
        in_data  = 3'd0;
        pop      = 1'b0;
        test_reset();
        test_basic();
        test_level_hold();
        test_overflow();
        test_underflow();
        test_push_pop();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
